// File: rtl/twos_complement_seq.sv
// Sliced sign-manipulation unit: pass / ones' / two's complement / absolute value,
// CHUNK bits per clock with the carry held in a register between slices.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one slice per cycle, idx 0..NCHUNK-1
//   DONE  | result and overflow registered onto the outputs; start accepted here too
module twos_complement_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] Output,
    output logic             ready,
    output logic             busy,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(1) << (WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             inv_q, inv_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;
    logic             ready_q, ready_d;

    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_op;
    logic [CHUNK:0]   sum;
    logic             neg;
    logic             last_slice;

    always_comb begin
        slice_a = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IW'(k)) begin
                slice_a = opnd_q[k*CHUNK +: CHUNK];
            end
        end
        slice_op   = inv_q ? ~slice_a : slice_a;
        sum        = {1'b0, slice_op} + {{CHUNK{1'b0}}, carry_q};
        neg        = A[WIDTH-1];
        last_slice = (idx_q == IW'(NCHUNK - 1));
    end

    always_comb begin
        state_d    = state_q;
        opnd_d     = opnd_q;
        inv_d      = inv_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        work_d     = work_q;
        ovf_pend_d = ovf_pend_q;
        out_d      = out_q;
        ovf_d      = ovf_q;
        ready_d    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) begin
                    out_d   = work_q;
                    ovf_d   = ovf_pend_q;
                    ready_d = 1'b1;
                end
                if (start) begin
                    opnd_d     = A;
                    inv_d      = (mode == 2'b01) || (mode == 2'b10) || ((mode == 2'b11) && neg);
                    carry_d    = (mode == 2'b10) || ((mode == 2'b11) && neg);
                    ovf_pend_d = mode[1] && (A == MIN_VAL);
                    idx_d      = '0;
                    work_d     = '0;
                    state_d    = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                for (int k = 0; k < NCHUNK; k++) begin
                    if (idx_q == IW'(k)) begin
                        work_d[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
                    end
                end
                carry_d = sum[CHUNK];
                if (last_slice) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            opnd_q     <= '0;
            inv_q      <= 1'b0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            work_q     <= '0;
            ovf_pend_q <= 1'b0;
            out_q      <= '0;
            ovf_q      <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            opnd_q     <= opnd_d;
            inv_q      <= inv_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            work_q     <= work_d;
            ovf_pend_q <= ovf_pend_d;
            out_q      <= out_d;
            ovf_q      <= ovf_d;
            ready_q    <= ready_d;
        end
    end

    // A back-to-back start puts the first RUN cycle under the ready pulse; busy yields to ready.
    assign busy     = (state_q == S_RUN) && !ready_q;
    assign ready    = ready_q;
    assign Output   = out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_twos_complement_seq.sv
// Bench for twos_complement_seq: an 8/4 and a 16/1 instance checked each cycle against
// an arithmetic model, plus directed operations with literal expected results.
module tb_twos_complement_seq;

    localparam int NC[2] = '{2, 16};
    localparam int WD[2] = '{8, 16};

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       start_r = '0;
    logic [1:0][1:0]  mode_r = '0;
    logic [1:0][15:0] a_r = '0;
    logic [7:0]       out0;
    logic [15:0]      out1;
    logic [1:0]       rdy, bsy, ovf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    twos_complement_seq #(.WIDTH(8), .CHUNK(4)) dut0 (
        .clk(clk), .reset(reset), .start(start_r[0]), .mode(mode_r[0]), .A(a_r[0][7:0]),
        .Output(out0), .ready(rdy[0]), .busy(bsy[0]), .overflow(ovf[0])
    );

    twos_complement_seq #(.WIDTH(16), .CHUNK(1)) dut1 (
        .clk(clk), .reset(reset), .start(start_r[1]), .mode(mode_r[1]), .A(a_r[1]),
        .Output(out1), .ready(rdy[1]), .busy(bsy[1]), .overflow(ovf[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] dut_out(input int i);
        return (i == 0) ? {8'h00, out0} : out1;
    endfunction

    // Returns {overflow, result} from plain modular arithmetic.
    function automatic logic [16:0] calc(input logic [1:0] m, input logic [15:0] a, input int w);
        int unsigned av, mask, minv, r;
        av   = a;
        mask = (32'd1 << w) - 1;
        minv = 32'd1 << (w - 1);
        case (m)
            2'd0:    r = av;
            2'd1:    r = ~av & mask;
            2'd2:    r = (0 - av) & mask;
            default: r = (av >= minv) ? ((0 - av) & mask) : av;
        endcase
        return {m[1] && (av == minv), r[15:0]};
    endfunction

    // Model: per-instance pending operation with its accept edge number.
    bit          mv = 0;
    int          ecnt = 0;
    bit          pend_v[2];
    int          pend_e[2];
    logic [15:0] pres[2], eo[2];
    logic        povf[2], eovf[2], er[2], eb[2];

    always @(posedge clk) begin
        ecnt++;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                mv        = 1;
                pend_v[i] = 0;
                eo[i]     = '0;
                eovf[i]   = 0;
                er[i]     = 0;
                eb[i]     = 0;
            end else begin
                bit running;
                running = pend_v[i] && ecnt >= pend_e[i] + 1 && ecnt <= pend_e[i] + NC[i];
                er[i] = 0;
                if (pend_v[i] && ecnt == pend_e[i] + NC[i] + 1) begin
                    eo[i]     = pres[i];
                    eovf[i]   = povf[i];
                    er[i]     = 1;
                    pend_v[i] = 0;
                end
                if (start_r[i] && !running) begin
                    logic [16:0] c;
                    c         = calc(mode_r[i], a_r[i], WD[i]);
                    pend_v[i] = 1;
                    pend_e[i] = ecnt;
                    pres[i]   = c[15:0];
                    povf[i]   = c[16];
                end
                eb[i] = pend_v[i] && ecnt >= pend_e[i] && ecnt <= pend_e[i] + NC[i] - 1 && !er[i];
            end
        end
    end

    always @(negedge clk) begin
        if (mv) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("model_out%0d", i), dut_out(i), eo[i]);
                chk($sformatf("model_ready%0d", i), rdy[i], er[i]);
                chk($sformatf("model_busy%0d", i), bsy[i], eb[i]);
                chk($sformatf("model_ovf%0d", i), ovf[i], eovf[i]);
                chk($sformatf("ready_busy_excl%0d", i), rdy[i] & bsy[i], 0);
            end
        end
    end

    task automatic run_op(input int i, input logic [1:0] m, input logic [15:0] a,
                          input logic [15:0] exp_o, input logic exp_v, input string nm);
        int  k;
        bit  got;
        @(negedge clk);
        start_r[i] = 1'b1;
        mode_r[i]  = m;
        a_r[i]     = a;
        k   = 0;
        got = 0;
        while (k < 60 && !got) begin
            @(negedge clk);
            k++;
            if (k == 1) start_r[i] = 1'b0;
            if (rdy[i]) got = 1;
        end
        chk({nm, "_latency"}, got ? k - 1 : 999, NC[i] + 1);
        chk({nm, "_out"}, dut_out(i), exp_o);
        chk({nm, "_ovf"}, ovf[i], exp_v);
    endtask

    initial begin
        int nrdy;
        repeat (3) @(negedge clk);
        chk("reset_out", out0, 0);
        chk("reset_ready", rdy[0], 0);
        chk("reset_busy", bsy[0], 0);
        chk("reset_ovf", ovf[0], 0);
        reset = 1'b0;

        // negate 5, busy for two cycles, then hold after ready
        @(negedge clk);
        start_r[0] = 1'b1; mode_r[0] = 2'd2; a_r[0] = 16'h0005;
        @(negedge clk); start_r[0] = 1'b0;
        chk("neg5_busy1", bsy[0], 1);
        @(negedge clk);
        chk("neg5_busy2", bsy[0], 1);
        @(negedge clk);
        chk("neg5_busy3", bsy[0], 0);
        @(negedge clk);
        chk("neg5_ready", rdy[0], 1);
        chk("neg5_out", out0, 8'hFB);
        chk("neg5_ovf", ovf[0], 0);
        @(negedge clk);
        chk("neg5_hold_rdy", rdy[0], 0);
        chk("neg5_hold_out", out0, 8'hFB);

        run_op(0, 2'd2, 16'h0000, 16'h0000, 0, "neg0");
        run_op(0, 2'd1, 16'h005A, 16'h00A5, 0, "ones5A");
        run_op(0, 2'd0, 16'h005A, 16'h005A, 0, "pass5A");
        run_op(0, 2'd3, 16'h0080, 16'h0080, 1, "abs80");
        run_op(0, 2'd3, 16'h00F0, 16'h0010, 0, "absF0");
        run_op(0, 2'd3, 16'h0023, 16'h0023, 0, "abs23");
        run_op(0, 2'd2, 16'h0080, 16'h0080, 1, "neg80");

        // start while busy is ignored; start held in DONE chains directly
        @(negedge clk);
        start_r[0] = 1'b1; mode_r[0] = 2'd2; a_r[0] = 16'h0001;
        nrdy = 0;
        @(negedge clk); start_r[0] = 1'b0;
        nrdy += int'(rdy[0]);
        @(negedge clk); start_r[0] = 1'b1; a_r[0] = 16'h007F;
        nrdy += int'(rdy[0]);
        @(negedge clk); a_r[0] = 16'h0002;
        nrdy += int'(rdy[0]);
        @(negedge clk); start_r[0] = 1'b0;
        nrdy += int'(rdy[0]);
        chk("b2b_first_ready", rdy[0], 1);
        chk("b2b_first_out", out0, 8'hFF);
        @(negedge clk); nrdy += int'(rdy[0]);
        @(negedge clk); nrdy += int'(rdy[0]);
        @(negedge clk); nrdy += int'(rdy[0]);
        chk("b2b_second_ready", rdy[0], 1);
        chk("b2b_second_out", out0, 8'hFE);
        chk("b2b_ready_count", nrdy, 2);

        // reset on the first RUN cycle abandons the operation
        @(negedge clk);
        start_r[0] = 1'b1; mode_r[0] = 2'd2; a_r[0] = 16'h0005;
        @(negedge clk); start_r[0] = 1'b0; reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("rst_out", out0, 0);
        chk("rst_busy", bsy[0], 0);
        chk("rst_ready", rdy[0], 0);
        chk("rst_ovf", ovf[0], 0);
        nrdy = 0;
        repeat (6) begin
            @(negedge clk);
            nrdy += int'(rdy[0]);
        end
        chk("rst_no_ready", nrdy, 0);

        run_op(1, 2'd2, 16'h0001, 16'hFFFF, 0, "w16_neg1");
        run_op(1, 2'd2, 16'h0100, 16'hFF00, 0, "w16_neg100");
        run_op(1, 2'd3, 16'h8000, 16'h8000, 1, "w16_abs8000");
        run_op(1, 2'd1, 16'h1234, 16'hEDCB, 0, "w16_ones");

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
